// File: rtl/uart_tx_scheduler.sv
// Purpose : round-robin share of one byte UART TX among NUM_REQ 32-bit word requesters,
//           framing each word as header (HDR_BASE|id) + 4 data bytes LSB first.
// Latency : grant one edge after req_valid is seen idle; one byte per tx handshake; 1 idle cycle between frames.
// Backpr. : tx_byte/tx_valid hold while tx_ready is low; requests wait (unacked) while busy.
// Option  : define UART_SCHED_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module uart_tx_scheduler #(
  parameter int          NUM_REQ  = 4,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   frame_done
);

  // Context of the frame being sent: who owns it and the word latched at grant.
  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] word;
  } frame_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_D0   = 3'd2,
    ST_D1   = 3'd3,
    ST_D2   = 3'd4,
    ST_D3   = 3'd5
`ifdef UART_SCHED_CHECKSUM_EN
    ,
    ST_CSUM = 3'd6
`endif
  } state_t;

  state_t      state;
  frame_t      cur;
  logic [2:0]  ptr;

  logic [2:0]  winner;
  logic        any_valid;
  logic [31:0] win_word;
  int          best_d;
  int          d;

  logic        xfer;
  assign xfer = tx_valid && tx_ready;

  // Round-robin pick: smallest distance above the pointer among valid requesters.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    best_d    = NUM_REQ;
    d         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (req_valid[i] && (d < best_d)) begin
        best_d    = d;
        winner    = 3'(i);
        any_valid = 1'b1;
      end
    end
  end

  // Select the winning requester's word for latching at grant.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == winner) win_word = req_data[32*i +: 32];
    end
  end

`ifdef UART_SCHED_CHECKSUM_EN
  logic [7:0] csum;
  // Checksum covers header and all four data bytes of the latched frame.
  always_comb begin
    csum = {HDR_BASE[7:3], cur.id} ^ cur.word[7:0] ^ cur.word[15:8]
         ^ cur.word[23:16] ^ cur.word[31:24];
  end
`endif

  // Frame sequencer; every output is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      ptr        <= 3'(NUM_REQ - 1);
      req_ready  <= '0;
      tx_byte    <= '0;
      tx_valid   <= 1'b0;
      grant_id   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      req_ready  <= '0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            req_ready[winner] <= 1'b1;
            cur.id            <= winner;
            cur.word          <= win_word;
            grant_id          <= winner;
            busy              <= 1'b1;
            tx_valid          <= 1'b1;
            tx_byte           <= {HDR_BASE[7:3], winner};
            state             <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            tx_byte <= cur.word[7:0];
            state   <= ST_D0;
          end
        end
        ST_D0: begin
          if (xfer) begin
            tx_byte <= cur.word[15:8];
            state   <= ST_D1;
          end
        end
        ST_D1: begin
          if (xfer) begin
            tx_byte <= cur.word[23:16];
            state   <= ST_D2;
          end
        end
        ST_D2: begin
          if (xfer) begin
            tx_byte <= cur.word[31:24];
            state   <= ST_D3;
          end
        end
        ST_D3: begin
          if (xfer) begin
`ifdef UART_SCHED_CHECKSUM_EN
            tx_byte <= csum;
            state   <= ST_CSUM;
`else
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            ptr        <= cur.id;
            state      <= ST_IDLE;
`endif
          end
        end
`ifdef UART_SCHED_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            ptr        <= cur.id;
            state      <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single-frame vector table plus
// hand sequences for round-robin, stalls, mid-frame requests, reset and drops.
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [31:0]     words [N];
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [7:0]      tx_byte;
  logic            tx_valid;
  logic            tx_ready;
  logic [2:0]      grant_id;
  logic            busy;
  logic            frame_done;

  assign req_data = {words[3], words[2], words[1], words[0]};

  uart_tx_scheduler #(.NUM_REQ(N), .HDR_BASE(8'hA0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [7:0]   bytes_q [$];
  logic [N-1:0] rr_log  [$];

  // Observe transfers and accept pulses mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) bytes_q.push_back(tx_byte);
    if (req_ready != '0) rr_log.push_back(req_ready);
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] word;
    logic [39:0] exp;   // header in [39:32], then bytes in send order
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output logic [N-1:0] seen);
    bit got;
    got  = 1'b0;
    seen = '0;
    for (int c = 0; c < 40; c++) begin
      if (!got) begin
        @(negedge clk);
        if (req_ready != '0) begin
          got  = 1'b1;
          seen = req_ready;
        end
      end
    end
    if (!got) begin
      checks++;
      errs++;
      $display("FAIL wait_ready: timeout, got none expected a req_ready pulse");
    end
  endtask

  task automatic wait_done(output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int c = 0; c < 60; c++) begin
      if (!got) begin
        @(negedge clk);
        cyc++;
        if (frame_done) got = 1'b1;
      end
    end
    if (!got) begin
      checks++;
      errs++;
      $display("FAIL wait_done: timeout, got no frame_done expected one");
    end
  endtask

  task automatic check_bytes(input string name, input logic [39:0] exp_in);
    logic [39:0] e;
    e = exp_in;
    check({name, "_len"}, 64'(bytes_q.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < bytes_q.size()) check({name, "_byte"}, 64'(bytes_q[k]), 64'(e[39:32]));
      e = e << 8;
    end
  endtask

  logic [N-1:0] seen;
  int           cyc;
  int           nrdy;
  logic [7:0]   exp8;
  logic         prev_stall;
  logic [7:0]   prev_byte;
  bit           done_seen;

  initial begin
    vecs[0] = '{id: 2'd0, word: 32'h11223344, exp: 40'hA0_44_33_22_11};
    vecs[1] = '{id: 2'd1, word: 32'hDEADBEEF, exp: 40'hA1_EF_BE_AD_DE};
    vecs[2] = '{id: 2'd2, word: 32'h000000FF, exp: 40'hA2_FF_00_00_00};
    vecs[3] = '{id: 2'd3, word: 32'h8001027F, exp: 40'hA3_7F_02_01_80};
    vecs[4] = '{id: 2'd3, word: 32'hA5A55A5A, exp: 40'hA3_5A_5A_A5_A5};
    vecs[5] = '{id: 2'd0, word: 32'hFFFFFFFF, exp: 40'hA0_FF_FF_FF_FF};

    // Reset with all four requesters already valid, data i+1.
    reset_n   = 1'b0;
    tx_ready  = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) words[i] = 32'(i + 1);
    #12;
    check("rst_req_ready",  64'(req_ready),  64'd0);
    check("rst_tx_byte",    64'(tx_byte),    64'd0);
    check("rst_tx_valid",   64'(tx_valid),   64'd0);
    check("rst_grant_id",   64'(grant_id),   64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk); #1;
    bytes_q.delete();
    rr_log.delete();
    reset_n = 1'b1;

    // Round-robin with everyone held: 0,1,2,3,0.
    nrdy = 0;
    for (int c = 0; c < 100; c++) begin
      if (nrdy < 5) begin
        @(negedge clk);
        if (req_ready != '0) nrdy++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_done(cyc);
    check("rr_grants", 64'(rr_log.size()), 64'd5);
    for (int f = 0; f < 5; f++) begin
      if (f < rr_log.size()) check("rr_order", 64'(rr_log[f]), 64'(4'b0001 << (f % 4)));
      for (int k = 0; k < 5; k++) begin
        exp8 = (k == 0) ? (8'hA0 | 8'(f % 4)) : ((k == 1) ? 8'(f % 4 + 1) : 8'h00);
        if (f*5 + k < bytes_q.size()) check("rr_bytes", 64'(bytes_q[f*5 + k]), 64'(exp8));
      end
    end

    // Table of single frames, tx_ready held high.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      bytes_q.delete();
      rr_log.delete();
      words[vecs[v].id]     = vecs[v].word;
      req_valid[vecs[v].id] = 1'b1;
      wait_ready(seen);
      check("vec_ready", 64'(seen),     64'(4'b0001 << vecs[v].id));
      check("vec_grant", 64'(grant_id), 64'({1'b0, vecs[v].id}));
      check("vec_busy",  64'(busy),     64'd1);
      @(posedge clk); #1;
      req_valid[vecs[v].id] = 1'b0;
      wait_done(cyc);
      check("vec_frame_len", 64'(cyc),      64'd5);
      check("vec_fd_busy",   64'(busy),     64'd0);
      check("vec_fd_txv",    64'(tx_valid), 64'd0);
      check_bytes("vec", vecs[v].exp);
      check("vec_one_ready", 64'(rr_log.size()), 64'd1);
      @(negedge clk);
      check("vec_fd_pulse",  64'(frame_done), 64'd0);
    end

    // Stalls: tx_ready toggling; bytes must hold while stalled.
    @(posedge clk); #1;
    bytes_q.delete();
    words[1]     = 32'hDEADBEEF;
    req_valid[1] = 1'b1;
    wait_ready(seen);
    check("stall_ready", 64'(seen), 64'd2);
    prev_stall = 1'b0;
    prev_byte  = '0;
    done_seen  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!done_seen) begin
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        tx_ready     = ~tx_ready;
        @(negedge clk);
        if (prev_stall) begin
          check("stall_hold_valid", 64'(tx_valid), 64'd1);
          check("stall_hold_byte",  64'(tx_byte),  64'(prev_byte));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
        if (frame_done) done_seen = 1'b1;
      end
    end
    if (!done_seen) check("stall_done", 64'd0, 64'd1);
    tx_ready = 1'b1;
    check_bytes("stall", 40'hA1_EF_BE_AD_DE);

    // Requests arriving mid-frame wait; pointer=2 gives 3 then 0.
    @(posedge clk); #1;
    rr_log.delete();
    words[2]     = 32'h0BADF00D;
    req_valid[2] = 1'b1;
    wait_ready(seen);
    check("mid_first", 64'(seen), 64'd4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    words[0] = 32'h00000010;
    words[3] = 32'h00000030;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    wait_done(cyc);
    check("mid_no_ready_busy", 64'(rr_log.size()), 64'd1);
    wait_ready(seen);
    check("mid_second", 64'(seen),     64'd8);
    check("mid_second_id", 64'(grant_id), 64'd3);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_done(cyc);
    wait_ready(seen);
    check("mid_third", 64'(seen), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_done(cyc);

    // Reset during D1; requester 0 stays valid and gets a fresh frame.
    @(posedge clk); #1;
    words[0]     = 32'hCAFEF00D;
    req_valid[0] = 1'b1;
    wait_ready(seen);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_tx_valid", 64'(tx_valid), 64'd0);
    check("arst_busy",     64'(busy),     64'd0);
    check("arst_grant",    64'(grant_id), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bytes_q.delete();
    reset_n = 1'b1;
    wait_ready(seen);
    check("arst_regrant", 64'(seen), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_done(cyc);
    check_bytes("arst", 40'hA0_0D_F0_FE_CA);

    // One-cycle request pulse during a frame is lost.
    @(posedge clk); #1;
    rr_log.delete();
    words[1]     = 32'h12345678;
    req_valid[1] = 1'b1;
    wait_ready(seen);
    check("drop_first", 64'(seen), 64'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_done(cyc);
    repeat (10) @(negedge clk);
    check("drop_no_ready", 64'(rr_log.size()), 64'd1);
    check("drop_idle_txv", 64'(tx_valid), 64'd0);
    check("drop_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
